// File: rtl/pkg_bus_rtc.sv
// Shared types and constants for the RTC bus responder: FSM states,
// phase encoding of A_D and the idle level of the active-low strobes.
package pkg_bus_rtc;

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    ESCRITURA  = 2'd1,
    LECTURA    = 2'd2,
    ESPERA_FIN = 2'd3
  } estado_t;

  localparam logic FASE_DIR    = 1'b0;
  localparam logic FASE_DATO   = 1'b1;
  localparam logic STROBE_IDLE = 1'b1;

endpackage

// File: rtl/banco_registros.sv
// RTC register bank: DEPTH x ANCHO, synchronous write, registered read.
// The whole bank is cleared by the asynchronous reset.
module banco_registros #(
  parameter int DEPTH = 16,
  parameter int ANCHO = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    dir_esc,
  input  logic [ANCHO-1:0] dato_esc,
  input  logic [AW-1:0]    dir_lec,
  output logic [ANCHO-1:0] dato_lec
);

  logic [ANCHO-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dato_lec <= '0;
    end else begin
      if (we) begin
        mem[dir_esc] <= dato_esc;
      end
      dato_lec <= mem[dir_lec];
    end
  end

endmodule

// File: rtl/respondedor_bus_rtc.sv
// Bus-side responder emulating the RTC register bank behind the multiplexed
// CS/RD/WR/A_D strobe interface; strobes are synchronised before use.
module respondedor_bus_rtc
  import pkg_bus_rtc::*;
#(
  parameter int DEPTH = 16,
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             CS,
  input  logic             RD,
  input  logic             WR,
  input  logic             A_D,
  input  logic [ANCHO-1:0] dato_in,
  output logic [ANCHO-1:0] dato_out,
  output logic             dato_oe,
  output logic [ANCHO-1:0] dir_actual,
  output logic             escritura_hecha,
  output logic             lectura_hecha,
  output logic             error_bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]       ctl_meta_reg, ctl_sync_reg;
  logic [ANCHO-1:0] dato_meta_reg, dato_s;
  logic             cs_s, rd_s, wr_s, ad_s;

  estado_t          estado_reg, estado_next;
  logic             fase_reg, fase_next;
  logic [ANCHO-1:0] captura_reg, captura_next;
  logic [ANCHO-1:0] dir_reg, dir_next;
  logic [ANCHO-1:0] dato_out_reg, dato_out_next;
  logic             oe_reg, oe_next;
  logic             esc_reg, esc_next;
  logic             lec_reg, lec_next;
  logic             err_reg, err_next;
  logic             banco_we;
  logic             en_rango;
  logic [ANCHO-1:0] dato_lec;

  // Two-flop synchronisers, idle-high out of reset so no spurious cycle starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_meta_reg  <= {4{STROBE_IDLE}};
      ctl_sync_reg  <= {4{STROBE_IDLE}};
      dato_meta_reg <= '1;
      dato_s        <= '1;
    end else begin
      ctl_meta_reg  <= {CS, RD, WR, A_D};
      ctl_sync_reg  <= ctl_meta_reg;
      dato_meta_reg <= dato_in;
      dato_s        <= dato_meta_reg;
    end
  end

  assign {cs_s, rd_s, wr_s, ad_s} = ctl_sync_reg;
  assign en_rango = 32'(dir_reg) < 32'(DEPTH);

  banco_registros #(
    .DEPTH (DEPTH),
    .ANCHO (ANCHO),
    .AW    (AW)
  ) u_banco (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (banco_we),
    .dir_esc  (dir_reg[AW-1:0]),
    .dato_esc (captura_reg),
    .dir_lec  (dir_reg[AW-1:0]),
    .dato_lec (dato_lec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg <= REPOSO;
    end else begin
      estado_reg <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      REPOSO: begin
        if (!cs_s) begin
          if (!wr_s && rd_s)       estado_next = ESCRITURA;
          else if (!rd_s && wr_s)  estado_next = LECTURA;
          else if (!rd_s && !wr_s) estado_next = ESPERA_FIN;
        end
      end
      ESCRITURA:  if (wr_s || cs_s) estado_next = REPOSO;
      LECTURA:    if (rd_s || cs_s) estado_next = REPOSO;
      ESPERA_FIN: if (cs_s && rd_s && wr_s) estado_next = REPOSO;
      default:    estado_next = REPOSO;
    endcase
  end

  // Next values of the registered outputs; everything holds unless a rule fires.
  always_comb begin
    fase_next     = fase_reg;
    captura_next  = captura_reg;
    dir_next      = dir_reg;
    dato_out_next = dato_out_reg;
    oe_next       = oe_reg;
    esc_next      = 1'b0;
    lec_next      = 1'b0;
    err_next      = err_reg;
    banco_we      = 1'b0;
    case (estado_reg)
      REPOSO: begin
        if (estado_next == ESCRITURA) begin
          fase_next    = ad_s;
          captura_next = dato_s;
        end else if (estado_next == LECTURA) begin
          // The bank read port already tracks the stable pointer.
          oe_next       = 1'b1;
          dato_out_next = en_rango ? dato_lec : '0;
          if (!en_rango) err_next = 1'b1;
        end else if (estado_next == ESPERA_FIN) begin
          err_next = 1'b1;
        end
      end
      ESCRITURA: begin
        if (wr_s || cs_s) begin
          case (fase_reg)
            FASE_DIR: dir_next = captura_reg;
            FASE_DATO: begin
              if (en_rango) begin
                banco_we = 1'b1;
                esc_next = 1'b1;
              end else begin
                err_next = 1'b1;
              end
            end
          endcase
        end else begin
          captura_next = dato_s;
        end
      end
      LECTURA: begin
        if (rd_s || cs_s) begin
          oe_next  = 1'b0;
          lec_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fase_reg     <= FASE_DIR;
      captura_reg  <= '0;
      dir_reg      <= '0;
      dato_out_reg <= '0;
      oe_reg       <= 1'b0;
      esc_reg      <= 1'b0;
      lec_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      fase_reg     <= fase_next;
      captura_reg  <= captura_next;
      dir_reg      <= dir_next;
      dato_out_reg <= dato_out_next;
      oe_reg       <= oe_next;
      esc_reg      <= esc_next;
      lec_reg      <= lec_next;
      err_reg      <= err_next;
    end
  end

  assign dato_out        = dato_out_reg;
  assign dato_oe         = oe_reg;
  assign dir_actual      = dir_reg;
  assign escritura_hecha = esc_reg;
  assign lectura_hecha   = lec_reg;
  assign error_bus       = err_reg;

endmodule
